// File: rtl/fp_normalize_seq.sv
// rtl/fp_normalize_seq.sv - sequential sign/magnitude normaliser for the 12-bit linear-to-float converter
// Produces sign, 3-bit exponent, 4-bit significand and round bit, one shift per cycle.
module fp_normalize_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        s_out,
    output logic [2:0]  e_out,
    output logic [3:0]  f_out,
    output logic        fifth_bit
);

    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] d_reg, d_reg_nxt;
    logic        sign, sign_nxt;
    logic [10:0] sr, sr_nxt;
    logic [2:0]  exp_cnt, exp_nxt;
    logic [2:0]  step, step_nxt;
    logic        s_nxt, fifth_nxt;
    logic [2:0]  e_nxt;
    logic [3:0]  f_nxt;
    logic [10:0] mag;
    logic        norm;
    logic        finish;

    // -2048 has no positive counterpart; it saturates to the largest magnitude
    always_comb begin
        mag = d_reg[10:0];
        if (d_reg[11]) begin
            if (d_reg == 12'h800) mag = 11'h7FF;
            else                  mag = ~d_reg[10:0] + 11'd1;
        end
    end

    assign norm = sr[10] | (exp_cnt == 3'd0);

    always_comb begin
        state_nxt = state;
        d_reg_nxt = d_reg;
        sign_nxt  = sign;
        sr_nxt    = sr;
        exp_nxt   = exp_cnt;
        step_nxt  = step;
        s_nxt     = s_out;
        e_nxt     = e_out;
        f_nxt     = f_out;
        fifth_nxt = fifth_bit;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    d_reg_nxt = d_in;
                    state_nxt = ABS;
                end
            end
            ABS: begin
                sign_nxt  = d_reg[11];
                sr_nxt    = mag;
                exp_nxt   = 3'd7;
                step_nxt  = 3'd0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (EARLY_EXIT) begin
                    if (norm) begin
                        finish = 1'b1;
                    end else begin
                        sr_nxt  = {sr[9:0], 1'b0};
                        exp_nxt = exp_cnt - 3'd1;
                    end
                end else begin
                    // fixed latency: eight evaluations, shifting only while unnormalised
                    if (step == 3'd7) begin
                        finish = 1'b1;
                    end else begin
                        if (!norm) begin
                            sr_nxt  = {sr[9:0], 1'b0};
                            exp_nxt = exp_cnt - 3'd1;
                        end
                        step_nxt = step + 3'd1;
                    end
                end
                if (finish) begin
                    state_nxt = DONE;
                    s_nxt     = sign;
                    e_nxt     = exp_cnt;
                    f_nxt     = sr[10:7];
                    fifth_nxt = sr[6];
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_reg     <= 12'd0;
            sign      <= 1'b0;
            sr        <= 11'd0;
            exp_cnt   <= 3'd0;
            step      <= 3'd0;
            s_out     <= 1'b0;
            e_out     <= 3'd0;
            f_out     <= 4'd0;
            fifth_bit <= 1'b0;
        end else begin
            state     <= state_nxt;
            d_reg     <= d_reg_nxt;
            sign      <= sign_nxt;
            sr        <= sr_nxt;
            exp_cnt   <= exp_nxt;
            step      <= step_nxt;
            s_out     <= s_nxt;
            e_out     <= e_nxt;
            f_out     <= f_nxt;
            fifth_bit <= fifth_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule
